// File: rtl/gol_pkg.sv
// Shared constants and types for the Game-of-Life row pipeline.
package gol_pkg;

    localparam int unsigned ROW_W  = 1280;
    localparam int unsigned N_ROWS = 720;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StDrain,
        StSwapWait
    } writer_state_e;

endpackage

// File: rtl/row_fifo2.sv
// Two-entry register FIFO; the caller never pushes when full (unless popping) nor pops when empty.
module row_fifo2 #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic [1:0]       count
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/next_state_writer.sv
// Write-back stage: queues next-state rows, writes them to the frame BRAM, tracks frame end
// and waits for a bank swap before starting the next frame.
module next_state_writer
    import gol_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              row_valid,
    input  logic              calc_flag_in,
    input  logic [ADDR_W-1:0] row_idx,
    input  logic [ROW_W-1:0]  row_data,
    output logic              row_ready,
    input  logic              wr_gnt,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ROW_W-1:0]  wr_data,
    output logic              wr_bank,
    output logic              frame_done,
    input  logic              swap_ack,
    output logic              seq_err,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LastRow = ADDR_W'(N_ROWS - 1);

    writer_state_e state_q, state_d;

    logic                     push, pop;
    logic [1:0]               count, count_d;
    logic [ROW_W+ADDR_W-1:0]  fifo_wdata, fifo_rdata;
    logic [ADDR_W-1:0]        head_addr;
    logic [ROW_W-1:0]         head_data;

    logic                     row_ready_q, row_ready_d;
    logic                     wr_en_q;
    logic [ADDR_W-1:0]        wr_addr_q;
    logic [ROW_W-1:0]         wr_data_q;
    logic                     wr_bank_q, wr_bank_d;
    logic                     frame_done_q, frame_done_d;
    logic                     seq_err_q, seq_err_d;
    logic [ADDR_W-1:0]        exp_row_q, exp_row_d;
    logic                     last_pend_q, last_pend_d;

    assign fifo_wdata             = {row_idx, row_data};
    assign {head_addr, head_data} = fifo_rdata;

    row_fifo2 #(
        .Width (ROW_W + ADDR_W)
    ) u_row_fifo2 (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (count)
    );

    always_comb begin
        push         = row_valid & calc_flag_in & row_ready_q;
        pop          = (count != 2'd0) & wr_gnt & ((state_q == StIdle) | (state_q == StWrite));
        count_d      = count + 2'(push) - 2'(pop);
        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        frame_done_d = 1'b0;
        seq_err_d    = seq_err_q;
        exp_row_d    = exp_row_q;
        // Remembers that the frame's last row has gone out while later rows still drain.
        last_pend_d  = last_pend_q | (pop & (head_addr == LastRow));

        if (push) begin
            seq_err_d = seq_err_q | (row_idx != exp_row_q);
            exp_row_d = (row_idx == LastRow) ? '0 : row_idx + 1'b1;
        end

        unique case (state_q)
            StIdle, StWrite: begin
                if (count_d != 2'd0) begin
                    state_d = StWrite;
                end else if (last_pend_d) begin
                    state_d     = StDrain;
                    last_pend_d = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                frame_done_d = 1'b1;
                state_d      = StSwapWait;
            end
            StSwapWait: begin
                if (swap_ack) begin
                    wr_bank_d = ~wr_bank_q;
                    exp_row_d = '0;
                    state_d   = StIdle;
                end
            end
        endcase

        // Based on next-cycle occupancy so a registered ready never admits a row into a full FIFO.
        row_ready_d = (count_d < 2'(DEPTH)) & (state_d != StSwapWait);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            row_ready_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_bank_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seq_err_q    <= 1'b0;
            exp_row_q    <= '0;
            last_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_ready_q  <= row_ready_d;
            wr_en_q      <= pop;
            if (pop) begin
                wr_addr_q <= head_addr;
                wr_data_q <= head_data;
            end
            wr_bank_q    <= wr_bank_d;
            frame_done_q <= frame_done_d;
            seq_err_q    <= seq_err_d;
            exp_row_q    <= exp_row_d;
            last_pend_q  <= last_pend_d;
        end
    end

    assign row_ready  = row_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_bank    = wr_bank_q;
    assign frame_done = frame_done_q;
    assign seq_err    = seq_err_q;
    assign busy       = (count != 2'd0) | (state_q != StIdle);

endmodule
